// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: turns byte/half/word accesses into word-aligned
// valid/ready requests with strobes. Optional macro: MEM_ACCESS_MISALIGN_FLAG_EN.
module mem_access_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_write_m,
  input  logic [1:0]       result_src_m,
  input  logic [WIDTH-1:0] alu_result_m,
  input  logic [WIDTH-1:0] write_data_m,
  input  logic [2:0]       funct3_m,
  output logic             stall_m,
  output logic [WIDTH-1:0] read_data_m,
  output logic             misaligned_m,
  output logic             dmem_req_valid,
  input  logic             dmem_req_ready,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_wstrb,
  input  logic             dmem_resp_valid,
  input  logic [WIDTH-1:0] dmem_resp_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t     state;
  logic [1:0] off_q;
  logic [2:0] funct3_q;

  logic             access_pending;
  logic             flag_fault;
  logic [WIDTH-1:0] st_wdata;
  logic [3:0]       st_wstrb;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] load_ext;

  assign access_pending = mem_write_m | (result_src_m == 2'b01);

`ifdef MEM_ACCESS_MISALIGN_FLAG_EN
  logic misaligned_c;
  assign misaligned_c = ((funct3_m[1:0] == 2'b01) && alu_result_m[0]) ||
                        (funct3_m[1] && (alu_result_m[1:0] != 2'b00));
  assign flag_fault   = access_pending && misaligned_c;
`else
  // Without the flag, low address bits below the access size are simply dropped.
  assign flag_fault   = 1'b0;
`endif

  // Held low while rst is high so the output shows its reset value even if an access is pending.
  assign stall_m = !rst && (((state == S_IDLE) && access_pending) ||
                            (state == S_REQ) || (state == S_WAIT));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    st_wdata = write_data_m;
    st_wstrb = 4'b1111;
    case (funct3_m[1:0])
      2'b00: begin
        st_wdata = {4{write_data_m[7:0]}};
        st_wstrb = 4'b0001 << alu_result_m[1:0];
      end
      2'b01: begin
        st_wdata = {2{write_data_m[15:0]}};
        st_wstrb = 4'b0011 << {alu_result_m[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte  = dmem_resp_rdata[7:0];
    case (off_q)
      2'b01:   ld_byte = dmem_resp_rdata[15:8];
      2'b10:   ld_byte = dmem_resp_rdata[23:16];
      2'b11:   ld_byte = dmem_resp_rdata[31:24];
      default: ;
    endcase
    ld_half  = off_q[1] ? dmem_resp_rdata[31:16] : dmem_resp_rdata[15:0];
    load_ext = dmem_resp_rdata;
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   load_ext = {{16{~funct3_q[2] & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      off_q          <= 2'b00;
      funct3_q       <= 3'b000;
      read_data_m    <= '0;
      misaligned_m   <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_wstrb     <= 4'b0000;
    end else begin
      misaligned_m <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flag_fault) begin
            state        <= S_DONE;
            misaligned_m <= 1'b1;
            if (!mem_write_m) read_data_m <= '0;
          end else if (access_pending) begin
            state          <= S_REQ;
            dmem_req_valid <= 1'b1;
            dmem_we        <= mem_write_m;
            dmem_addr      <= {alu_result_m[WIDTH-1:2], 2'b00};
            dmem_wdata     <= st_wdata;
            dmem_wstrb     <= mem_write_m ? st_wstrb : 4'b0000;
            funct3_q       <= funct3_m;
            off_q          <= alu_result_m[1:0];
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_resp_valid) begin
            if (!dmem_we) read_data_m <= load_ext;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a per-cycle responder drives ready/response
// and every access is checked against hand-computed request fields, stall length and load data.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic [2:0]  funct3_m;
  logic        stall_m;
  logic [31:0] read_data_m;
  logic        misaligned_m;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_rdata;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m), .funct3_m(funct3_m),
    .stall_m(stall_m), .read_data_m(read_data_m), .misaligned_m(misaligned_m),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_rdata(dmem_resp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " stall_m"},        32'(stall_m),        32'd0);
    check({tag, " dmem_req_valid"}, 32'(dmem_req_valid), 32'd0);
    check({tag, " dmem_we"},        32'(dmem_we),        32'd0);
    check({tag, " misaligned_m"},   32'(misaligned_m),   32'd0);
    check({tag, " dmem_addr"},      dmem_addr,           32'h0);
    check({tag, " dmem_wdata"},     dmem_wdata,          32'h0);
    check({tag, " dmem_wstrb"},     32'(dmem_wstrb),     32'd0);
    check({tag, " read_data_m"},    read_data_m,         32'h0);
  endtask

  // ready_low: cycles (counted from the IDLE detect cycle) with ready held low.
  // resp_delay: WAIT cycles without a response before the one-cycle response pulse.
  task automatic access(input string tag, input logic st, input logic ld,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] rdata, input int ready_low, input int resp_delay,
                        input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_wstrb, input int e_stall, input int e_accepts,
                        input logic e_mis, input logic [31:0] e_rd);
    int cyc = 0, stalls = 0, accepts = 0, wait_cnt = 0;
    bit waiting = 0, done = 0, resp_now = 0;
    @(posedge clk); #1;
    mem_write_m     = st;
    result_src_m    = ld ? 2'b01 : 2'b00;
    alu_result_m    = addr;
    write_data_m    = wd;
    funct3_m        = f3;
    dmem_req_ready  = (ready_low == 0);
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = rdata;
    while (!done && cyc < 32) begin
      @(negedge clk);
      if (stall_m) stalls++;
      if (resp_now) waiting = 0;
      else if (waiting) wait_cnt--;
      if (dmem_req_valid) begin
        check({tag, " addr"},  dmem_addr,         e_addr);
        check({tag, " wstrb"}, 32'(dmem_wstrb),   32'(e_wstrb));
        check({tag, " we"},    32'(dmem_we),      32'(st));
        if (st) check({tag, " wdata"}, dmem_wdata, e_wdata);
        if (dmem_req_ready) begin
          accepts++;
          waiting  = 1;
          wait_cnt = resp_delay;
        end
      end
      if (!stall_m) begin
        done = 1;
        check({tag, " stall cycles"}, 32'(stalls),       32'(e_stall));
        check({tag, " accepts"},      32'(accepts),      32'(e_accepts));
        check({tag, " misaligned"},   32'(misaligned_m), 32'(e_mis));
        check({tag, " read_data"},    read_data_m,       e_rd);
      end
      cyc++;
      if (!done) begin
        @(posedge clk); #1;
        dmem_req_ready  = (cyc >= ready_low);
        resp_now        = waiting && (wait_cnt == 0);
        dmem_resp_valid = resp_now;
      end
    end
    if (!done) check({tag, " completion"}, 32'(done), 32'd1);
    // Pipeline advances past DONE: next cycle carries a non-memory instruction.
    @(posedge clk); #1;
    mem_write_m     = 1'b0;
    result_src_m    = 2'b00;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    check({tag, " idle stall"},      32'(stall_m),        32'd0);
    check({tag, " idle misaligned"}, 32'(misaligned_m),   32'd0);
    check({tag, " idle req_valid"},  32'(dmem_req_valid), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    mem_write_m     = 1'b0;
    result_src_m    = 2'b00;
    alu_result_m    = '0;
    write_data_m    = '0;
    funct3_m        = 3'b000;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = '0;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    //      tag    st ld addr          wdata         f3      rdata         rl rd  e_addr        e_wdata       wstrb    stl acc mis e_rd
    access("SW",   1, 0, 32'h100, 32'hDEADBEEF, 3'b010, 32'h0,        0, 0, 32'h100, 32'hDEADBEEF, 4'b1111, 3, 1, 0, 32'h0);
    access("SB",   1, 0, 32'h103, 32'h000000A5, 3'b000, 32'h0,        0, 0, 32'h100, 32'hA5A5A5A5, 4'b1000, 3, 1, 0, 32'h0);
    access("LB",   0, 1, 32'h103, 32'h0,        3'b000, 32'hA5000000, 0, 0, 32'h100, 32'h0,        4'b0000, 3, 1, 0, 32'hFFFFFFA5);
    access("LBU",  0, 1, 32'h103, 32'h0,        3'b100, 32'hA5000000, 0, 0, 32'h100, 32'h0,        4'b0000, 3, 1, 0, 32'h000000A5);
    access("SH",   1, 0, 32'h106, 32'h1234BEEF, 3'b001, 32'h0,        0, 0, 32'h104, 32'hBEEFBEEF, 4'b1100, 3, 1, 0, 32'h000000A5);
    access("LH",   0, 1, 32'h102, 32'h0,        3'b001, 32'h80010000, 0, 0, 32'h100, 32'h0,        4'b0000, 3, 1, 0, 32'hFFFF8001);
    access("LHU",  0, 1, 32'h102, 32'h0,        3'b101, 32'h80010000, 0, 0, 32'h100, 32'h0,        4'b0000, 3, 1, 0, 32'h00008001);
    access("LB+",  0, 1, 32'h101, 32'h0,        3'b000, 32'h00007F00, 0, 0, 32'h100, 32'h0,        4'b0000, 3, 1, 0, 32'h0000007F);
    // Ready low for IDLE plus two REQ cycles, response in the second WAIT cycle: 6 stall cycles.
    access("LWslow", 0, 1, 32'h040, 32'h0,      3'b010, 32'h12345678, 3, 1, 32'h040, 32'h0,        4'b0000, 6, 1, 0, 32'h12345678);

    // Reset while waiting for the response of a load.
    @(posedge clk); #1;
    result_src_m    = 2'b01;
    alu_result_m    = 32'h300;
    funct3_m        = 3'b010;
    dmem_req_ready  = 1'b1;
    dmem_resp_rdata = 32'h55555555;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst-test REQ valid", 32'(dmem_req_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst-test WAIT stall", 32'(stall_m), 32'd1);
    check("rst-test WAIT valid", 32'(dmem_req_valid), 32'd0);
    rst          = 1'b1;
    result_src_m = 2'b00;
    dmem_req_ready = 1'b0;
    #2;
    check_reset_outputs("rst-in-wait");
    @(posedge clk); #1;
    rst             = 1'b0;
    dmem_resp_valid = 1'b1;
    @(negedge clk);
    check("late resp stall",     32'(stall_m),        32'd0);
    check("late resp req_valid", 32'(dmem_req_valid), 32'd0);
    @(posedge clk); #1;
    dmem_resp_valid = 1'b0;
    @(negedge clk);
    check("late resp read_data", read_data_m, 32'h0);
    check("late resp stall2",    32'(stall_m), 32'd0);

    access("SWpost", 1, 0, 32'h010, 32'h11223344, 3'b010, 32'h0,      0, 0, 32'h010, 32'h11223344, 4'b1111, 3, 1, 0, 32'h0);
    access("LHU2",   0, 1, 32'h202, 32'h0,        3'b101, 32'hABCD0000, 0, 0, 32'h200, 32'h0,      4'b0000, 3, 1, 0, 32'h0000ABCD);
`ifdef MEM_ACCESS_MISALIGN_FLAG_EN
    access("LWmis",  0, 1, 32'h201, 32'h0,        3'b010, 32'hCAFEF00D, 0, 0, 32'h200, 32'h0,      4'b0000, 1, 0, 1, 32'h0);
`else
    access("LWmis",  0, 1, 32'h201, 32'h0,        3'b010, 32'hCAFEF00D, 0, 0, 32'h200, 32'h0,      4'b0000, 3, 1, 0, 32'hCAFEF00D);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
